// File: rtl/uart_pkg.sv
// uart_pkg: frame-format and receiver-state types shared by the UART receiver
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;
  function automatic logic parity_of(logic [8:0] d, int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) p = p ^ (d[i] & (i < n));
    return p;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with valid/ready on both sides; a write into a full FIFO is taken when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic push, pop;
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_valid_o = !empty_o;
  assign wr_ready_o = !full_o || rd_ready_i;
  assign pop = rd_valid_o && rd_ready_i;
  assign push = wr_valid_i && wr_ready_o;
  assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with parity/framing checks and a show-ahead output FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ   = 100000000,
  parameter int      BAUD_RATE  = 9600,
  parameter int      OVERSAMPLE = 16,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 err_clear_i,
  output logic                 busy_o
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW = $clog2(DIV) + 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int FW = DATA_BITS + 2;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  rx_state_t state_q;
  logic [1:0] sync_q, smp_q;
  logic [CW-1:0] div_q;
  logic [SW-1:0] samp_q;
  logic [3:0] bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic parity_err_q, frame_err_q, overrun_q;
  logic rx_s, tick, decide, bit_v, push, push_ok, fifo_empty, unused_full;
  logic [FW-1:0] push_data, head;
  assign rx_s = sync_q[1];
  assign busy_o = state_q != ST_IDLE;
  assign tick = busy_o && div_q == DIV_LAST;
  assign decide = tick && samp_q == S_C;
  // third vote is the live sample taken on the deciding tick
  assign bit_v = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign push = decide && state_q == ST_STOP && bit_q == STOP_LAST;
  assign push_data = {shift_q, parity_err_q, frame_err_q | ~bit_v};
  assign overrun_o = overrun_q;
  assign {data_o, parity_err_o, frame_err_o} = fifo_empty ? '0 : head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= 2'b11;
      smp_q <= 2'b11;
      div_q <= '0;
      samp_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      div_q <= !busy_o || tick ? '0 : div_q + CW'(1);
      samp_q <= !busy_o ? '0 : tick ? (samp_q == S_LAST ? '0 : samp_q + SW'(1)) : samp_q;
      if (tick && samp_q == S_A) smp_q[0] <= rx_s;
      if (tick && samp_q == S_B) smp_q[1] <= rx_s;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q <= '0;
      shift_q <= '0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (!rx_s) begin
          state_q <= ST_START;
          bit_q <= '0;
          parity_err_q <= 1'b0;
          frame_err_q <= 1'b0;
        end
        ST_START: if (decide) state_q <= bit_v ? ST_IDLE : ST_DATA;
        ST_DATA: if (decide) begin
          shift_q <= {bit_v, shift_q[DATA_BITS-1:1]};
          bit_q <= bit_q == DATA_LAST ? '0 : bit_q + 4'd1;
          if (bit_q == DATA_LAST) state_q <= PARITY == PAR_NONE ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: if (decide) begin
          parity_err_q <= (parity_of(9'(shift_q), DATA_BITS) ^ bit_v) != (PARITY == PAR_ODD);
          state_q <= ST_STOP;
        end
        ST_STOP: if (decide) begin
          if (!bit_v) frame_err_q <= 1'b1;
          bit_q <= bit_q + 4'd1;
          if (bit_q == STOP_LAST) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overrun_q <= 1'b0;
    else if (push && !push_ok) overrun_q <= 1'b1;
    else if (err_clear_i) overrun_q <= 1'b0;
  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (push),
    .wr_ready_o (push_ok),
    .wr_data_i  (push_data),
    .rd_valid_o (data_valid_o),
    .rd_ready_i (data_ready_i),
    .rd_data_o  (head),
    .full_o     (unused_full),
    .empty_o    (fifo_empty)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: frame-level checks of two receiver configurations (8N1 and 8E2, 4-deep FIFO)
module tb_uart_rx_fifo;
  import uart_pkg::*;
  localparam int BIT = 160;
  typedef struct packed {
    logic [7:0] d;
    logic       p, s1, s2;
    logic [9:0] exp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rx_n = 1'b1, rdy_n = 1'b1, clr_n = 1'b0;
  logic rx_e = 1'b1, rdy_e = 1'b1, clr_e = 1'b0;
  logic [7:0] d_n, d_e;
  logic dv_n, pe_n, fe_n, ov_n, busy_n;
  logic dv_e, pe_e, fe_e, ov_e, busy_e;
  int vecs = 0, fails = 0, vcyc_n = 0, bcyc_n = 0, rd_n = 0, rd_e = 0;
  logic [9:0] got_n[$], got_e[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_n), .data_o(d_n), .data_valid_o(dv_n),
    .data_ready_i(rdy_n), .parity_err_o(pe_n), .frame_err_o(fe_n), .overrun_o(ov_n),
    .err_clear_i(clr_n), .busy_o(busy_n));
  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_e), .data_o(d_e), .data_valid_o(dv_e),
    .data_ready_i(rdy_e), .parity_err_o(pe_e), .frame_err_o(fe_e), .overrun_o(ov_e),
    .err_clear_i(clr_e), .busy_o(busy_e));
  always @(negedge clk) begin
    if (dv_n) vcyc_n++;
    if (busy_n) bcyc_n++;
    if (dv_n && rdy_n) got_n.push_back({d_n, pe_n, fe_n});
    if (dv_e && rdy_e) got_e.push_back({d_e, pe_e, fe_e});
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] fr_n(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction
  function automatic logic [15:0] fr_e(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    return {4'b0, s2, s1, p, d, 1'b0};
  endfunction
  task automatic send(input bit e, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (e) rx_e = bits[i]; else rx_n = bits[i];
      step(BIT);
    end
    if (e) rx_e = 1'b1; else rx_n = 1'b1;
  endtask
  task automatic expect_pop(input bit e, input string nm, input logic [9:0] exp);
    int sz, idx;
    sz = e ? got_e.size() : got_n.size();
    idx = e ? rd_e : rd_n;
    chk({nm, " count"}, 32'(sz - idx), 32'd1);
    if (sz > idx) chk(nm, 32'(e ? got_e[idx] : got_n[idx]), 32'(exp));
    if (e) rd_e = sz; else rd_n = sz;
  endtask
  initial begin
    int v0, b0, s0;
    logic [7:0] rd;
    logic rp, rs1, rs2;
    tbl[0] = '{8'h07, 1'b0, 1'b1, 1'b1, {8'h07, 2'b10}};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b1, {8'h07, 2'b00}};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, {8'h3C, 2'b01}};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, {8'h3C, 2'b11}};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, {8'hFF, 2'b00}};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b1, {8'h80, 2'b10}};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, {8'h00, 2'b10}};
    step(5);
    chk("reset n outputs", 32'({d_n, dv_n, pe_n, fe_n, ov_n, busy_n}), 32'd0);
    chk("reset e outputs", 32'({d_e, dv_e, pe_e, fe_e, ov_e, busy_e}), 32'd0);
    rst_n = 1'b1;
    step(20);
    v0 = vcyc_n;
    send(0, fr_n(8'hA5, 1'b1), 10);
    chk("t1 busy after stop", 32'(busy_n), 32'd0);
    step(BIT);
    expect_pop(0, "t1 a5", {8'hA5, 2'b00});
    chk("t1 valid cycles", 32'(vcyc_n - v0), 32'd1);
    v0 = vcyc_n;
    b0 = bcyc_n;
    s0 = got_n.size();
    rx_n = 1'b0;
    step(40);
    rx_n = 1'b1;
    step(2 * BIT);
    chk("t2 busy pulsed", 32'(bcyc_n > b0), 32'd1);
    chk("t2 busy back", 32'(busy_n), 32'd0);
    chk("t2 no valid", 32'(vcyc_n - v0), 32'd0);
    chk("t2 nothing pushed", 32'(got_n.size() - s0), 32'd0);
    for (int i = 0; i < 7; i++) begin
      send(1, fr_e(tbl[i].d, tbl[i].p, tbl[i].s1, tbl[i].s2), 12);
      step(BIT);
      expect_pop(1, $sformatf("tbl%0d", i), tbl[i].exp);
    end
    send(0, fr_n(8'h3C, 1'b0), 10);
    step(BIT);
    expect_pop(0, "t4 3c frame", {8'h3C, 2'b01});
    send(0, fr_n(8'h11, 1'b1), 10);
    step(BIT);
    expect_pop(0, "t4 11 clean", {8'h11, 2'b00});
    rdy_n = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(0, fr_n(8'(k), 1'b1), 10);
      step(BIT);
      if (k == 4) chk("t5 no overrun at 4", 32'(ov_n), 32'd0);
    end
    chk("t5 overrun", 32'(ov_n), 32'd1);
    chk("t5 head", 32'({dv_n, d_n}), 32'h101);
    clr_n = 1'b1;
    step(1);
    clr_n = 1'b0;
    chk("t5 overrun cleared", 32'(ov_n), 32'd0);
    s0 = got_n.size();
    rdy_n = 1'b1;
    step(10);
    chk("t5 drain count", 32'(got_n.size() - s0), 32'd4);
    for (int j = 0; j < 4 && s0 + j < got_n.size(); j++)
      chk($sformatf("t5 drain%0d", j), 32'(got_n[s0 + j]), 32'({8'(j + 1), 2'b00}));
    rd_n = got_n.size();
    chk("t5 empty", 32'(dv_n), 32'd0);
    rdy_n = 1'b0;
    send(0, fr_n(8'h33, 1'b1), 10);
    step(BIT);
    chk("t6 entry held", 32'({dv_n, d_n}), 32'h133);
    send(0, fr_n(8'hFF, 1'b1), 4);
    chk("t6 busy mid data", 32'(busy_n), 32'd1);
    rst_n = 1'b0;
    step(3);
    chk("t6 reset outputs", 32'({d_n, dv_n, pe_n, fe_n, ov_n, busy_n}), 32'd0);
    rst_n = 1'b1;
    rdy_n = 1'b1;
    step(BIT);
    send(0, fr_n(8'h5A, 1'b1), 10);
    step(BIT);
    expect_pop(0, "t6 5a", {8'h5A, 2'b00});
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rs1 = $urandom_range(0, 3) != 0;
      send(0, fr_n(rd, rs1), 10);
      step(BIT);
      expect_pop(0, $sformatf("rand n%0d", i), {rd, 1'b0, !rs1});
    end
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs1 = $urandom_range(0, 3) != 0;
      rs2 = $urandom_range(0, 3) != 0;
      send(1, fr_e(rd, rp, rs1, rs2), 12);
      step(BIT);
      expect_pop(1, $sformatf("rand e%0d", i), {rd, 1'($countones({rd, rp}) % 2), !(rs1 && rs2)});
    end
    chk("overrun e never", 32'(ov_e), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
